// File: rtl/i2c_read_from_memory_pkg.sv
// Shared definitions for the EEPROM read/write sequencers: sequencer states,
// device control code, R/W bit values and the control-byte helper.
package i2c_read_from_memory_pkg;

  // Upper nibble of every serial EEPROM device address.
  localparam logic [3:0] CTRL_CODE = 4'b1010;

  // Value of the R/W bit in the control byte.
  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WAKE    = 4'd1,
    ST_CTRL_W  = 4'd2,
    ST_ADDR_HI = 4'd3,
    ST_ADDR_LO = 4'd4,
    ST_CTRL_R  = 4'd5,
    ST_READ    = 4'd6,
    ST_PUSH    = 4'd7,
    ST_FINISH  = 4'd8,
    ST_ABORT   = 4'd9
  } seq_state_e;

  // Control byte sent after START / repeated START.
  function automatic logic [7:0] ctrl_byte(input logic [2:0] dev, input logic rw);
    return {CTRL_CODE, dev, rw};
  endfunction

  // States in which the sequencer is waiting on the core to finish a byte.
  function automatic logic is_byte_wait(input seq_state_e s);
    logic w;
    case (s)
      ST_CTRL_W, ST_ADDR_HI, ST_ADDR_LO, ST_CTRL_R, ST_READ: w = 1'b1;
      default:                                              w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/i2c_read_from_memory_if.sv
// Sequencer <-> byte-level I2C master core and downstream FIFO signals.
interface i2c_read_from_memory_if;
  // towards the I2C master core
  logic [6:0] address;
  logic [7:0] register;
  logic       mode;
  logic       master_ack;
  logic       byte_go;
  logic       I2C_en;
  logic       reset_I2C;
  logic       Start;
  logic       repeat_start;
  logic       Stop;
  // from the I2C master core
  logic       byte_done;
  logic       ack;
  logic [7:0] rx_data;
  // downstream FIFO
  logic [7:0] data_out;
  logic       write;
  logic       full;

  modport master (
    output address, register, mode, master_ack, byte_go, I2C_en, reset_I2C,
           Start, repeat_start, Stop, data_out, write,
    input  byte_done, ack, rx_data, full
  );

  modport slave (
    input  address, register, mode, master_ack, byte_go, I2C_en, reset_I2C,
           Start, repeat_start, Stop, data_out, write,
    output byte_done, ack, rx_data, full
  );
endinterface

// File: rtl/i2c_read_from_memory_byte_watchdog.sv
// Per-byte watchdog: counts enabled cycles since the last clear and raises
// timeout once LIMIT cycles have elapsed. The count saturates at LIMIT.
module i2c_byte_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;
  logic         timeout_q, timeout_d;

  // Next count: clear wins, otherwise count enabled cycles up to LIMIT.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != W'(LIMIT))) begin
      count_d = count_q + W'(1'b1);
    end else begin
      count_d = count_q;
    end
    timeout_d = (count_d == W'(LIMIT));
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/i2c_read_from_memory.sv
// Random-read sequencer: START, ctrl(W), addr_hi, addr_lo, repeated START,
// ctrl(R), N reads (ACK all but the last), STOP; each byte goes to a FIFO.
module i2c_read_from_memory
  import i2c_read_from_memory_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [11:0]                  number_of_bytes,
  input  logic [14:0]                  memory_address,
  input  logic [2:0]                   memory_number,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  i2c_read_from_memory_if.master       bus
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_e    state_q, state_d;
  logic [14:0]   addr_q, addr_d;
  logic [11:0]   remaining_q, remaining_d;
  logic [2:0]    dev_q, dev_d;
  logic [7:0]    hold_q, hold_d;
  logic [SW-1:0] settle_q, settle_d;

  logic [6:0]    address_q, address_d;
  logic [7:0]    register_q, register_d;
  logic          mode_q, mode_d;
  logic          master_ack_q, master_ack_d;
  logic          byte_go_q, byte_go_d;
  logic          i2c_en_q, i2c_en_d;
  logic          reset_i2c_q, reset_i2c_d;
  logic          start_q, start_d;
  logic          repeat_start_q, repeat_start_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          write_q, write_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          timeout_s;
  logic          wdog_en_s;
  logic          wr_ok_s;
  logic          wr_fail_s;
  logic [11:0]   rem_dec_s;

  assign wr_ok_s   = bus.byte_done & bus.ack;
  assign wr_fail_s = (bus.byte_done & ~bus.ack) | timeout_s;
  assign rem_dec_s = remaining_q - 12'd1;
  assign wdog_en_s = is_byte_wait(state_q);

  i2c_byte_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (byte_go_d),
    .en      (wdog_en_s),
    .timeout (timeout_s)
  );

  // Next-state and next-output logic; pulses default low, levels hold.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    dev_d          = dev_q;
    hold_d         = hold_q;
    settle_d       = settle_q;
    address_d      = address_q;
    register_d     = register_q;
    mode_d         = mode_q;
    master_ack_d   = master_ack_q;
    data_out_d     = data_out_q;
    error_d        = error_q;
    byte_go_d      = 1'b0;
    start_d        = 1'b0;
    repeat_start_d = 1'b0;
    stop_d         = 1'b0;
    write_d        = 1'b0;
    done_d         = 1'b0;
    reset_i2c_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          error_d = 1'b0;
          if (number_of_bytes != 12'd0) begin
            addr_d      = memory_address;
            remaining_d = number_of_bytes;
            dev_d       = memory_number;
            settle_d    = '0;
            state_d     = ST_WAKE;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAKE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          start_d    = 1'b1;
          address_d  = {CTRL_CODE, dev_q};
          mode_d     = RW_WR;
          register_d = ctrl_byte(dev_q, RW_WR);
          byte_go_d  = 1'b1;
          state_d    = ST_CTRL_W;
        end else begin
          settle_d = settle_q + SW'(1'b1);
        end
      end
      ST_CTRL_W: begin
        if (wr_ok_s) begin
          register_d = {1'b0, addr_q[14:8]};
          byte_go_d  = 1'b1;
          state_d    = ST_ADDR_HI;
        end else if (wr_fail_s) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_CTRL_W;
        end
      end
      ST_ADDR_HI: begin
        if (wr_ok_s) begin
          register_d = addr_q[7:0];
          byte_go_d  = 1'b1;
          state_d    = ST_ADDR_LO;
        end else if (wr_fail_s) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_ADDR_HI;
        end
      end
      ST_ADDR_LO: begin
        if (wr_ok_s) begin
          repeat_start_d = 1'b1;
          register_d     = ctrl_byte(dev_q, RW_RD);
          byte_go_d      = 1'b1;
          state_d        = ST_CTRL_R;
        end else if (wr_fail_s) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_ADDR_LO;
        end
      end
      ST_CTRL_R: begin
        if (wr_ok_s) begin
          mode_d       = RW_RD;
          master_ack_d = (remaining_q > 12'd1);
          byte_go_d    = 1'b1;
          state_d      = ST_READ;
        end else if (wr_fail_s) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_CTRL_R;
        end
      end
      ST_READ: begin
        if (bus.byte_done) begin
          hold_d  = bus.rx_data;
          state_d = ST_PUSH;
        end else if (timeout_s) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_PUSH: begin
        // The next byte is only requested once this one has left, so a
        // full FIFO simply stalls the bus without losing data.
        if (!bus.full) begin
          data_out_d  = hold_q;
          write_d     = 1'b1;
          remaining_d = rem_dec_s;
          if (rem_dec_s == 12'd0) begin
            stop_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            master_ack_d = (rem_dec_s > 12'd1);
            byte_go_d    = 1'b1;
            state_d      = ST_READ;
          end
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        stop_d  = 1'b1;
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    // Enable also covers the cycle that carries the final Stop request out
    // of FINISH/ABORT, so the core sees STOP while still enabled.
    i2c_en_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= 15'd0;
      remaining_q    <= 12'd0;
      dev_q          <= 3'd0;
      hold_q         <= 8'd0;
      settle_q       <= '0;
      address_q      <= 7'd0;
      register_q     <= 8'd0;
      mode_q         <= 1'b0;
      master_ack_q   <= 1'b0;
      byte_go_q      <= 1'b0;
      i2c_en_q       <= 1'b0;
      reset_i2c_q    <= 1'b0;
      start_q        <= 1'b0;
      repeat_start_q <= 1'b0;
      stop_q         <= 1'b0;
      data_out_q     <= 8'd0;
      write_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      dev_q          <= dev_d;
      hold_q         <= hold_d;
      settle_q       <= settle_d;
      address_q      <= address_d;
      register_q     <= register_d;
      mode_q         <= mode_d;
      master_ack_q   <= master_ack_d;
      byte_go_q      <= byte_go_d;
      i2c_en_q       <= i2c_en_d;
      reset_i2c_q    <= reset_i2c_d;
      start_q        <= start_d;
      repeat_start_q <= repeat_start_d;
      stop_q         <= stop_d;
      data_out_q     <= data_out_d;
      write_q        <= write_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign bus.address      = address_q;
  assign bus.register     = register_q;
  assign bus.mode         = mode_q;
  assign bus.master_ack   = master_ack_q;
  assign bus.byte_go      = byte_go_q;
  assign bus.I2C_en       = i2c_en_q;
  assign bus.reset_I2C    = reset_i2c_q;
  assign bus.Start        = start_q;
  assign bus.repeat_start = repeat_start_q;
  assign bus.Stop         = stop_q;
  assign bus.data_out     = data_out_q;
  assign bus.write        = write_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule
